// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising serial PRBS checker for a Fibonacci LFSR stream.
// Fills a reference, verifies it, then flywheels the reference and counts bit errors while locked.
module lfsr_prbs_checker #(
    parameter int WIDTH      = 4,
    parameter int TAP_A      = 3,
    parameter int TAP_B      = 1,
    parameter int LOCK_CNT   = 8,
    parameter int ERR_THRESH = 4,
    parameter int ERR_WINDOW = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_i,
    input  logic             valid_i,
    input  logic             clr_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             zero_o
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WERR_W  = $clog2(ERR_THRESH + 1);
    localparam int WBEAT_W = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WERR_W-1:0]  WERR_LIMIT = WERR_W'(ERR_THRESH);
    localparam logic [WBEAT_W-1:0] WBEAT_LAST = WBEAT_W'(ERR_WINDOW - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_SEED,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   ref_reg, ref_next;
    logic [FILL_W-1:0]  fill_reg, fill_next;
    logic [MATCH_W-1:0] match_reg, match_next;
    logic [WBEAT_W-1:0] wbeat_reg, wbeat_next;
    logic [WERR_W-1:0]  werr_reg, werr_next;
    logic [CNT_W-1:0]   err_cnt_reg, err_cnt_next;
    logic               locked_reg, err_reg, zero_reg;

    logic               expected;
    logic               ref_zero;
    logic               err_hit;
    logic [WIDTH-1:0]   ref_load;
    logic [WIDTH-1:0]   ref_fly;

    assign expected = ref_reg[TAP_A] ^ ref_reg[TAP_B];
    assign ref_zero = (ref_reg == '0);

    // Two shifted views of the reference: one takes the received bit, one its own prediction.
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign ref_load[gi] = ref_reg[gi-1];
            assign ref_fly[gi]  = ref_reg[gi-1];
        end
    endgenerate
    assign ref_load[0] = bit_i;
    assign ref_fly[0]  = expected;

    always_comb begin
        state_next = state_reg;
        ref_next   = ref_reg;
        fill_next  = fill_reg;
        match_next = match_reg;
        wbeat_next = wbeat_reg;
        werr_next  = werr_reg;
        err_hit    = 1'b0;

        if (valid_i) begin
            case (state_reg)
                ST_SEED: begin
                    ref_next = ref_load;
                    if (fill_reg == FILL_LAST) begin
                        fill_next  = '0;
                        match_next = '0;
                        state_next = ST_VERIFY;
                    end else begin
                        fill_next = fill_reg + FILL_W'(1);
                    end
                end

                ST_VERIFY: begin
                    ref_next = ref_load;
                    // A zero reference predicts zero forever, so it must never earn credit.
                    if ((bit_i == expected) && !ref_zero) begin
                        if (match_reg == MATCH_LAST) begin
                            match_next = '0;
                            wbeat_next = '0;
                            werr_next  = '0;
                            state_next = ST_LOCKED;
                        end else begin
                            match_next = match_reg + MATCH_W'(1);
                        end
                    end else begin
                        match_next = '0;
                    end
                end

                ST_LOCKED: begin
                    ref_next = ref_fly;
                    err_hit  = (bit_i != expected);
                    if (wbeat_reg == WBEAT_LAST) begin
                        wbeat_next = '0;
                        werr_next  = err_hit ? WERR_W'(1) : '0;
                    end else begin
                        wbeat_next = wbeat_reg + WBEAT_W'(1);
                        werr_next  = err_hit ? (werr_reg + WERR_W'(1)) : werr_reg;
                    end
                    if (werr_next == WERR_LIMIT) begin
                        fill_next  = '0;
                        state_next = ST_SEED;
                    end
                end

                default: begin
                    state_next = ST_SEED;
                end
            endcase
        end
    end

    // A clear coinciding with an error leaves that error counted.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (clr_i) begin
            err_cnt_next = err_hit ? CNT_W'(1) : '0;
        end else if (err_hit && (err_cnt_reg != CNT_MAX)) begin
            err_cnt_next = err_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_SEED;
            ref_reg     <= '0;
            fill_reg    <= '0;
            match_reg   <= '0;
            wbeat_reg   <= '0;
            werr_reg    <= '0;
            err_cnt_reg <= '0;
            locked_reg  <= 1'b0;
            err_reg     <= 1'b0;
            zero_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ref_reg     <= ref_next;
            fill_reg    <= fill_next;
            match_reg   <= match_next;
            wbeat_reg   <= wbeat_next;
            werr_reg    <= werr_next;
            err_cnt_reg <= err_cnt_next;
            locked_reg  <= (state_next == ST_LOCKED);
            err_reg     <= err_hit;
            zero_reg    <= ref_zero && (state_reg != ST_SEED);
        end
    end

    assign locked_o  = locked_reg;
    assign err_o     = err_reg;
    assign err_cnt_o = err_cnt_reg;
    assign zero_o    = zero_reg;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Scoreboard bench for lfsr_prbs_checker: two instances (default and a narrow-counter, wide-window
// variant) share one stimulus stream; a behavioural model predicts every cycle's outputs.
module tb_lfsr_prbs_checker;

    logic        clk;
    logic        reset;
    logic        bit_i;
    logic        valid_i;
    logic        clr_i;
    logic        locked_a, err_a, zero_a;
    logic [15:0] cnt_a;
    logic        locked_b, err_b, zero_b;
    logic [3:0]  cnt_b;

    int n_total = 0;
    int n_bad   = 0;
    int pi      = 0;

    typedef struct {
        int         st;
        logic [3:0] rf;
        int         fill, match, wbeat, werr, cnt;
        bit         locked, err, zero;
    } mst_t;

    typedef struct {
        bit la, ea, za, lb, eb, zb;
        int ca, cb;
    } exp_t;

    mst_t ma, mb;
    exp_t sb_q[$];

    lfsr_prbs_checker dut_a (
        .clk(clk), .reset(reset), .bit_i(bit_i), .valid_i(valid_i), .clr_i(clr_i),
        .locked_o(locked_a), .err_o(err_a), .err_cnt_o(cnt_a), .zero_o(zero_a)
    );

    lfsr_prbs_checker #(.CNT_W(4), .ERR_WINDOW(256), .ERR_THRESH(32)) dut_b (
        .clk(clk), .reset(reset), .bit_i(bit_i), .valid_i(valid_i), .clr_i(clr_i),
        .locked_o(locked_b), .err_o(err_b), .err_cnt_o(cnt_b), .zero_o(zero_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference stream "000101" repeating (period of x^4+x^2+1).
    function automatic bit pat(input int i);
        logic [5:0] p;
        p = 6'b000101;
        return p[5 - (i % 6)];
    endfunction

    function automatic mst_t mstep(input mst_t s, input bit r, input bit b, input bit v,
                                   input bit c, input int win, input int thr, input int cmax);
        mst_t n;
        bit   e;
        bit   hit;
        n     = s;
        n.err = 1'b0;
        hit   = 1'b0;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        n.zero = (s.rf == 4'd0) && (s.st != 0);
        e = s.rf[3] ^ s.rf[1];
        if (v) begin
            case (s.st)
                0: begin
                    n.rf   = {s.rf[2:0], b};
                    n.fill = s.fill + 1;
                    if (n.fill == 4) begin
                        n.st = 1; n.fill = 0; n.match = 0;
                    end
                end
                1: begin
                    n.rf = {s.rf[2:0], b};
                    if (b == e && s.rf != 4'd0) n.match = s.match + 1;
                    else n.match = 0;
                    if (n.match == 8) begin
                        n.st = 2; n.match = 0; n.wbeat = 0; n.werr = 0;
                    end
                end
                default: begin
                    n.rf  = {s.rf[2:0], e};
                    hit   = (b != e);
                    n.err = hit;
                    if (s.wbeat == win - 1) begin
                        n.wbeat = 0;
                        n.werr  = hit ? 1 : 0;
                    end else begin
                        n.wbeat = s.wbeat + 1;
                        n.werr  = s.werr + (hit ? 1 : 0);
                    end
                    if (n.werr == thr) begin
                        n.st = 0; n.fill = 0;
                    end
                end
            endcase
        end
        if (c) n.cnt = hit ? 1 : 0;
        else if (hit && s.cnt < cmax) n.cnt = s.cnt + 1;
        n.locked = (n.st == 2);
        return n;
    endfunction

    // One clock: drive inputs, push the predicted outputs, then pop and compare after the edge.
    task automatic step(input bit r, input bit b, input bit v, input bit c);
        exp_t e;
        reset   = r;
        bit_i   = b;
        valid_i = v;
        clr_i   = c;
        ma = mstep(ma, r, b, v, c, 16, 4, 65535);
        mb = mstep(mb, r, b, v, c, 256, 32, 15);
        e.la = ma.locked; e.ea = ma.err; e.za = ma.zero; e.ca = ma.cnt;
        e.lb = mb.locked; e.eb = mb.err; e.zb = mb.zero; e.cb = mb.cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val("a_locked", locked_a, e.la);
        check_val("a_err",    err_a,    e.ea);
        check_val("a_cnt",    cnt_a,    e.ca);
        check_val("a_zero",   zero_a,   e.za);
        check_val("b_locked", locked_b, e.lb);
        check_val("b_err",    err_b,    e.eb);
        check_val("b_cnt",    cnt_b,    e.cb);
        check_val("b_zero",   zero_b,   e.zb);
        $display("t=%0t r=%0b v=%0b b=%0b c=%0b | a lk=%0b er=%0b cnt=%0d z=%0b | b lk=%0b er=%0b cnt=%0d z=%0b",
                 $time, r, v, b, c, locked_a, err_a, cnt_a, zero_a, locked_b, err_b, cnt_b, zero_b);
    endtask

    task automatic clean(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, pat(pi), 1'b1, 1'b0);
            pi++;
        end
    endtask

    task automatic bad_beat(input bit c);
        step(1'b0, !pat(pi), 1'b1, c);
        pi++;
    endtask

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        reset = 1'b1; bit_i = 1'b0; valid_i = 1'b0; clr_i = 1'b0;

        // T1: reset state, then lock on the 12th clean beat
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("rst_locked", locked_a, 0);
        check_val("rst_err",    err_a,    0);
        check_val("rst_cnt",    cnt_a,    0);
        check_val("rst_zero",   zero_a,   0);
        pi = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, pat(pi), 1'b1, 1'b0);
            pi++;
            if (k == 11) check_val("t1_prelock", locked_a, 0);
            if (k == 12) check_val("t1_lock",    locked_a, 1);
        end
        clean(12);
        check_val("t1_cnt", cnt_a, 0);

        // T2: single error while locked
        bad_beat(1'b0);
        check_val("t2_err",  err_a,    1);
        check_val("t2_cnt",  cnt_a,    1);
        check_val("t2_lock", locked_a, 1);
        clean(19);
        check_val("t2_hold", cnt_a, 1);
        step(1'b0, pat(pi), 1'b1, 1'b1);
        pi++;
        check_val("t2_clr", cnt_a, 0);

        // T3: four errors inside one window drop lock; clean stream relocks after 12 beats
        for (int k = 1; k <= 4; k++) begin
            bad_beat(1'b0);
            if (k == 3) check_val("t3_still", locked_a, 1);
        end
        check_val("t3_unlock", locked_a, 0);
        check_val("t3_err",    err_a,    1);
        check_val("t3_cnt",    cnt_a,    4);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, pat(pi), 1'b1, 1'b0);
            pi++;
            if (k == 11) check_val("t3_prerelock", locked_a, 0);
            if (k == 12) check_val("t3_relock",    locked_a, 1);
        end
        check_val("t3_cnt_held", cnt_a, 4);

        // Reset while locked overrides valid_i and clr_i
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_val("rst2_locked", locked_a, 0);
        check_val("rst2_cnt",    cnt_a,    0);
        check_val("rst2_err",    err_a,    0);
        check_val("rst2_b_cnt",  cnt_b,    0);

        // T4: all-zero stream can never lock
        for (int k = 1; k <= 64; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check_val("t4_zero",   zero_a,   (k >= 5) ? 1 : 0);
            check_val("t4_locked", locked_a, 0);
        end

        // T5: reset mid-VERIFY, then lock with valid_i toggling
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_val("t5_rst_zero",   zero_a,   0);
        check_val("t5_rst_locked", locked_a, 0);
        check_val("t5_rst_cnt",    cnt_a,    0);
        pi = 0;
        begin
            int vb;
            vb = 0;
            for (int j = 0; j < 24; j++) begin
                bit v;
                bit b;
                v = (j % 2 == 0);
                b = v ? pat(pi) : 1'($urandom_range(0, 1));
                step(1'b0, b, v, 1'b0);
                if (v) begin
                    pi++;
                    vb++;
                    if (vb == 11) check_val("t5_prelock", locked_a, 0);
                end
                if (vb == 12) check_val("t5_lock", locked_a, 1);
            end
        end

        // T6: narrow counter saturates, clear with coincident error yields one
        for (int n = 0; n < 20; n++) begin
            bad_beat(1'b0);
            clean(3);
        end
        check_val("t6_sat",    cnt_b,    15);
        check_val("t6_locked", locked_b, 1);
        bad_beat(1'b1);
        check_val("t6_clr_err", cnt_b, 1);
        check_val("t6_err",     err_b, 1);
        clean(4);

        check_val("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
